// File: rtl/eeg_frame_serializer.sv
// Decimates oscillator updates into frames and streams each one as
// a header word followed by sign-extended channel words.
module eeg_frame_serializer #(
    parameter int WIDTH          = 18,
    parameter int NUM_CH         = 21,
    parameter int SAMPLE_DIVISOR = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clk_4khz_en,
    input  logic                    enable,
    input  logic [NUM_CH*WIDTH-1:0] ch_packed,
    input  logic [2:0]              state_select,
    input  logic [2:0]              theta_phase,
    input  logic                    beta_quiet,
    input  logic                    sr_amplification,
    output logic [31:0]             m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [15:0]             frame_index,
    output logic [15:0]             overrun_count,
    output logic                    busy
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH + 1) : 1;
    localparam int CW = (SAMPLE_DIVISOR > 1) ? $clog2(SAMPLE_DIVISOR) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t                  state_q, state_d;
    logic                    prev_en_q, prev_en_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_CH*WIDTH-1:0] shadow_q, shadow_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_last_q, m_last_d;
    logic [31:0]             m_data_q, m_data_d;
    logic [15:0]             frame_q, frame_d;
    logic [15:0]             overrun_q, overrun_d;

    logic          rise, tick, hs, last_hs, capture, drop;
    logic [IW-1:0] nxt_idx;
    logic [WIDTH-1:0] sel;
    logic [31:0]   hdr_word;
    logic [31:0]   sel_word;

    always_comb begin
        rise    = clk_4khz_en & ~prev_en_q;
        tick    = rise && (cnt_q == CW'(SAMPLE_DIVISOR - 1));
        hs      = m_valid_q & m_ready;
        last_hs = (state_q == DATA) && hs && (idx_q == IW'(NUM_CH - 1));
        capture = tick && enable && ((state_q == IDLE) || last_hs);
        drop    = tick && enable && !capture;

        hdr_word = {frame_q + 16'd1, state_select, theta_phase,
                    beta_quiet, sr_amplification, 8'(NUM_CH)};

        // Channel feeding the next data beat: 0 after the header
        nxt_idx = (state_q == HDR) ? '0 : idx_q + IW'(1);
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (nxt_idx == IW'(i)) sel = shadow_q[i*WIDTH +: WIDTH];
        end
        sel_word = {{(32-WIDTH){sel[WIDTH-1]}}, sel};
    end

    always_comb begin
        prev_en_d = clk_4khz_en;
        cnt_d     = cnt_q;
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        frame_d   = frame_q;
        overrun_d = overrun_q;

        if (rise) cnt_d = tick ? '0 : cnt_q + CW'(1);

        if (capture) begin
            frame_d  = frame_q + 16'd1;
            shadow_d = ch_packed;
        end
        if (drop && overrun_q != 16'hFFFF) overrun_d = overrun_q + 16'd1;

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d   = HDR;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    m_data_d  = hdr_word;
                end
            end
            HDR: begin
                if (hs) begin
                    state_d  = DATA;
                    idx_d    = '0;
                    m_data_d = sel_word;
                    m_last_d = (NUM_CH == 1);
                end
            end
            DATA: begin
                if (last_hs) begin
                    if (capture) begin
                        state_d  = HDR;
                        m_data_d = hdr_word;
                    end else begin
                        state_d   = IDLE;
                        m_valid_d = 1'b0;
                        m_data_d  = '0;
                    end
                    m_last_d = 1'b0;
                end else if (hs) begin
                    idx_d    = nxt_idx;
                    m_data_d = sel_word;
                    m_last_d = (nxt_idx == IW'(NUM_CH - 1));
                end
            end
            default: begin
                state_d   = IDLE;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                m_data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_en_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            idx_q     <= '0;
            shadow_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            frame_q   <= '0;
            overrun_q <= '0;
        end else begin
            prev_en_q <= prev_en_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            frame_q   <= frame_d;
            overrun_q <= overrun_d;
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_last        = m_last_q;
    assign frame_index   = frame_q;
    assign overrun_count = overrun_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_eeg_frame_serializer.sv
// Directed bench for eeg_frame_serializer: vector table of frames plus
// stall/overrun, back-to-back, enable-drop and mid-frame reset sequences.
module tb_eeg_frame_serializer;

    localparam int W = 18;
    localparam int N = 21;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en4 = 1'b0;
    logic           enable = 1'b0;
    logic [N*W-1:0] ch = '0;
    logic [2:0]     ss = '0;
    logic [2:0]     tp = '0;
    logic           bq = 1'b0;
    logic           sr = 1'b0;
    logic [31:0]    m_data;
    logic           m_valid;
    logic           m_ready = 1'b1;
    logic           m_last;
    logic [15:0]    fi;
    logic [15:0]    oc;
    logic           busy;

    eeg_frame_serializer #(.WIDTH(W), .NUM_CH(N), .SAMPLE_DIVISOR(4)) dut (
        .clk(clk), .rst(rst), .clk_4khz_en(en4), .enable(enable),
        .ch_packed(ch), .state_select(ss), .theta_phase(tp),
        .beta_quiet(bq), .sr_amplification(sr),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .frame_index(fi), .overrun_count(oc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] c0, c20, cm;
        logic [2:0]   ss, tp;
        logic         bq, sr;
        logic [31:0]  hdr, e0, e20, em;
    } vec_t;

    vec_t        vt[3];
    int          total = 0;
    int          bad = 0;
    logic [31:0] words[64];
    logic        lasts[64];
    int          nw;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one-cycle strobe; returns just after the edge that saw it high
    task automatic pulse();
        en4 = 1'b1;
        step();
        en4 = 1'b0;
    endtask

    task automatic pulses(input int n);
        repeat (n) begin
            step();
            pulse();
        end
    endtask

    task automatic set_in(input vec_t v);
        for (int i = 0; i < N; i++) ch[i*W +: W] = v.cm;
        ch[0 +: W]       = v.c0;
        ch[20*W +: W]    = v.c20;
        ss = v.ss;
        tp = v.tp;
        bq = v.bq;
        sr = v.sr;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) ch[i*W +: W] = 18'h0AAAA + W'(i);
        ss = 3'b000;
        tp = 3'b000;
        bq = ~bq;
        sr = ~sr;
    endtask

    task automatic collect(input int stop_at, input int drop_at);
        bit got = 0;
        nw = 0;
        for (int c = 0; c < 400; c++) begin
            if (nw == drop_at) enable = 1'b0;
            if (nw == stop_at) begin
                got = 1;
                break;
            end
            if (m_valid && m_ready) begin
                words[nw] = m_data;
                lasts[nw] = m_last;
                nw++;
                step();
                if (lasts[nw-1]) begin
                    got = 1;
                    break;
                end
            end else begin
                step();
            end
        end
        if (!got) chk("collect_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_frame(input string nm, input logic [31:0] hdr,
                               input logic [31:0] e0, input logic [31:0] em,
                               input logic [31:0] e20);
        int nl = 0;
        for (int i = 0; i < nw; i++) if (lasts[i]) nl++;
        chk({nm, "_words"}, 32'(nw), 32'd22);
        chk({nm, "_hdr"}, words[0], hdr);
        chk({nm, "_ch0"}, words[1], e0);
        chk({nm, "_ch10"}, words[11], em);
        chk({nm, "_ch20"}, words[21], e20);
        chk({nm, "_last_pos"}, 32'(lasts[21]), 32'd1);
        chk({nm, "_last_cnt"}, 32'(nl), 32'd1);
    endtask

    initial begin
        int cyc;
        bit anyv;

        vt[0] = '{18'h3F000, 18'h01FFF, 18'h00005, 3'b101, 3'b011, 1'b1,
                  1'b0, 32'h0001AE15, 32'hFFFFF000, 32'h00001FFF,
                  32'h00000005};
        vt[1] = '{18'h1FFFF, 18'h20000, 18'h3FFFF, 3'b010, 3'b110, 1'b0,
                  1'b1, 32'h00025915, 32'h0001FFFF, 32'hFFFE0000,
                  32'hFFFFFFFF};
        vt[2] = '{18'h00000, 18'h2AAAA, 18'h15555, 3'b111, 3'b111, 1'b1,
                  1'b1, 32'h0003FF15, 32'h00000000, 32'hFFFEAAAA,
                  32'h00015555};

        rst = 1'b1;
        repeat (3) step();
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_last", 32'(m_last), 32'd0);
        chk("rst_data", m_data, 32'd0);
        chk("rst_frame", 32'(fi), 32'd0);
        chk("rst_overrun", 32'(oc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        enable = 1'b1;

        for (int v = 0; v < 3; v++) begin
            set_in(vt[v]);
            pulses(3);
            chk("pre_tick_idle", 32'(m_valid), 32'd0);
            pulses(1);
            chk("tick_valid", 32'(m_valid), 32'd1);
            chk("tick_frame", 32'(fi), 32'(v + 1));
            scramble();
            collect(-1, -1);
            check_frame("vec", vt[v].hdr, vt[v].e0, vt[v].em, vt[v].e20);
        end

        // sink stalled across three more ticks
        set_in(vt[0]);
        m_ready = 1'b0;
        pulses(4);
        chk("stall_hdr", m_data, 32'h0004AE15);
        pulses(12);
        chk("stall_hold", m_data, 32'h0004AE15);
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_overrun", 32'(oc), 32'd3);
        chk("stall_frame", 32'(fi), 32'd4);
        m_ready = 1'b1;
        collect(-1, -1);
        check_frame("stall", 32'h0004AE15, 32'hFFFFF000, 32'h5, 32'h1FFF);
        pulses(4);
        chk("after_stall_hdr", m_data, 32'h0005AE15);
        collect(-1, -1);
        check_frame("f5", 32'h0005AE15, 32'hFFFFF000, 32'h5, 32'h1FFF);

        // tick lands on the last-beat handshake
        m_ready = 1'b0;
        pulses(4);
        pulses(3);
        m_ready = 1'b1;
        cyc = 0;
        while (!(m_valid && m_last) && cyc < 100) begin
            step();
            cyc++;
        end
        chk("b2b_reach_last", 32'(m_valid && m_last), 32'd1);
        pulse();
        chk("b2b_valid", 32'(m_valid), 32'd1);
        chk("b2b_hdr", m_data, 32'h0007AE15);
        chk("b2b_overrun", 32'(oc), 32'd3);
        chk("b2b_frame", 32'(fi), 32'd7);
        collect(-1, -1);
        check_frame("b2b", 32'h0007AE15, 32'hFFFFF000, 32'h5, 32'h1FFF);

        // enable removed after data word 10
        pulses(4);
        collect(-1, 11);
        check_frame("endrop", 32'h0008AE15, 32'hFFFFF000, 32'h5, 32'h1FFF);
        pulses(8);
        chk("endrop_valid", 32'(m_valid), 32'd0);
        chk("endrop_busy", 32'(busy), 32'd0);
        chk("endrop_overrun", 32'(oc), 32'd3);
        chk("endrop_frame", 32'(fi), 32'd8);

        // reset during data word 5
        enable = 1'b1;
        pulses(4);
        collect(6, -1);
        chk("mrst_words", 32'(nw), 32'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_valid", 32'(m_valid), 32'd0);
        chk("mrst_frame", 32'(fi), 32'd0);
        chk("mrst_overrun", 32'(oc), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        anyv = 0;
        repeat (5) begin
            step();
            if (m_valid) anyv = 1;
        end
        chk("mrst_quiet", 32'(anyv), 32'd0);
        pulses(4);
        chk("mrst_new_hdr", m_data, 32'h0001AE15);
        collect(-1, -1);
        check_frame("mrst", 32'h0001AE15, 32'hFFFFF000, 32'h5, 32'h1FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
